// File: rtl/axi_lite_slave_register.sv
// AXI4-Lite slave exposing REG_CNT word-wide registers with byte-strobed writes.
// AW and W are captured independently; a write commits as soon as both are available.
module axi_lite_slave_register #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 32,
  parameter int REG_CNT    = 1,
  parameter int START_ADDR = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  output logic                              s_axi_awready,
  input  logic                              s_axi_awvalid,
  input  logic [ADDR_WIDTH-1:0]             s_axi_awaddr,
  input  logic [2:0]                        s_axi_awprot,
  output logic                              s_axi_wready,
  input  logic                              s_axi_wvalid,
  input  logic [BUS_WIDTH/8-1:0]            s_axi_wstrb,
  input  logic [BUS_WIDTH-1:0]              s_axi_wdata,
  input  logic                              s_axi_bready,
  output logic                              s_axi_bvalid,
  output logic [1:0]                        s_axi_bresp,
  output logic                              s_axi_arready,
  input  logic                              s_axi_arvalid,
  input  logic [ADDR_WIDTH-1:0]             s_axi_araddr,
  input  logic                              s_axi_rready,
  output logic                              s_axi_rvalid,
  output logic [BUS_WIDTH-1:0]              s_axi_rdata,
  output logic [1:0]                        s_axi_rresp,
  output logic [REG_CNT-1:0][BUS_WIDTH-1:0] registers,
  output logic [BUS_WIDTH-1:0]              register_write,
  output logic [REG_CNT-1:0]                register_wr_en
);

  localparam int STRB_W = BUS_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(START_ADDR);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [ADDR_WIDTH-1:0] reg_index(input logic [ADDR_WIDTH-1:0] addr);
    return (addr - BASE) >> LSB;
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >= BASE) && (reg_index(addr) < ADDR_WIDTH'(REG_CNT));
  endfunction

  function automatic logic [BUS_WIDTH-1:0] merge_bytes(input logic [BUS_WIDTH-1:0] old_val,
                                                       input logic [BUS_WIDTH-1:0] new_val,
                                                       input logic [STRB_W-1:0]    strb);
    logic [BUS_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  logic                  unused_prot;
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [BUS_WIDTH-1:0]  w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  aw_fire, w_fire, ar_fire;
  logic                  commit, wr_ok;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [BUS_WIDTH-1:0]  wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [BUS_WIDTH-1:0]  sel_old;
  logic [BUS_WIDTH-1:0]  rd_word;

  assign unused_prot   = ^s_axi_awprot;
  assign s_axi_awready = ~aw_held & ~s_axi_bvalid;
  assign s_axi_wready  = ~w_held & ~s_axi_bvalid;
  assign s_axi_arready = ~s_axi_rvalid;

  assign aw_fire = s_axi_awvalid & s_axi_awready;
  assign w_fire  = s_axi_wvalid & s_axi_wready;
  assign ar_fire = s_axi_arvalid & s_axi_arready;

  // A channel arriving this cycle is used directly, so a same-cycle AW+W commits immediately
  assign wr_addr = aw_held ? aw_addr_q : s_axi_awaddr;
  assign wr_data = w_held ? w_data_q : s_axi_wdata;
  assign wr_strb = w_held ? w_strb_q : s_axi_wstrb;
  assign commit  = (aw_held | aw_fire) & (w_held | w_fire);
  assign wr_ok   = commit & in_range(wr_addr);

  always_comb begin
    register_wr_en = '0;
    sel_old        = '0;
    for (int i = 0; i < REG_CNT; i++) begin
      if (reg_index(wr_addr) == ADDR_WIDTH'(i)) begin
        sel_old = registers[i];
        if (wr_ok) register_wr_en[i] = 1'b1;
      end
    end
    register_write = merge_bytes(sel_old, wr_data, wr_strb);
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < REG_CNT; i++) begin
      if (reg_index(s_axi_araddr) == ADDR_WIDTH'(i)) rd_word = registers[i];
    end
  end

  // Write-channel holding registers carry no reset; the held flags qualify them
  always_ff @(posedge clk) begin
    if (aw_fire) aw_addr_q <= s_axi_awaddr;
    if (w_fire) begin
      w_data_q <= s_axi_wdata;
      w_strb_q <= s_axi_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      registers    <= '0;
    end else begin
      if (commit) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= in_range(wr_addr) ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_fire) aw_held <= 1'b1;
        if (w_fire) w_held <= 1'b1;
        if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
      end
      for (int i = 0; i < REG_CNT; i++) begin
        if (register_wr_en[i]) registers[i] <= register_write;
      end
    end
  end

  // Read path: registered response, old contents on a same-edge write
  always_ff @(posedge clk) begin
    if (reset) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (ar_fire) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= in_range(s_axi_araddr) ? rd_word : '0;
      s_axi_rresp  <= in_range(s_axi_araddr) ? RESP_OKAY : RESP_DECERR;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_register.sv
// Self-checking bench for axi_lite_slave_register: directed corner sequences,
// a vector table, and randomized traffic checked against an array-based register model.
module tb_axi_lite_slave_register;

  localparam int REG_CNT = 4;
  localparam int START   = 0;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   awready, awvalid, wready, wvalid, bready, bvalid;
  logic                   arready, arvalid, rready, rvalid;
  logic [31:0]            awaddr, araddr, wdata, rdata, register_write;
  logic [2:0]             awprot;
  logic [3:0]             wstrb;
  logic [1:0]             bresp, rresp;
  logic [REG_CNT-1:0][31:0] registers;
  logic [REG_CNT-1:0]     wr_en;

  int checks   = 0;
  int failures = 0;
  logic [31:0] mem [REG_CNT];

  always #5 clk = ~clk;

  axi_lite_slave_register #(
    .ADDR_WIDTH(32), .BUS_WIDTH(32), .REG_CNT(REG_CNT), .START_ADDR(START)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axi_awready(awready), .s_axi_awvalid(awvalid), .s_axi_awaddr(awaddr), .s_axi_awprot(awprot),
    .s_axi_wready(wready), .s_axi_wvalid(wvalid), .s_axi_wstrb(wstrb), .s_axi_wdata(wdata),
    .s_axi_bready(bready), .s_axi_bvalid(bvalid), .s_axi_bresp(bresp),
    .s_axi_arready(arready), .s_axi_arvalid(arvalid), .s_axi_araddr(araddr),
    .s_axi_rready(rready), .s_axi_rvalid(rvalid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .registers(registers), .register_write(register_write), .register_wr_en(wr_en)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_in_range(input logic [31:0] a);
    return (a >= START) && (((a - START) / 4) < REG_CNT);
  endfunction

  function automatic int m_index(input logic [31:0] a);
    return int'((a - START) / 4);
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  task automatic check_regs();
    for (int i = 0; i < REG_CNT; i++) check("registers", registers[i], mem[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < REG_CNT; i++) mem[i] = 32'h0;
    #1;
    check_regs();
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_bresp_rresp", 32'({bresp, rresp}), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
    bit ok, aw_done, w_done, aw_hs, w_hs;
    int idx;
    logic [31:0] newv;
    logic [3:0] exp_en;
    ok = m_in_range(addr);
    idx = ok ? m_index(addr) : 0;
    newv = m_merge(mem[idx], data, strb);
    exp_en = ok ? 4'(1 << idx) : 4'b0;
    aw_done = 0;
    w_done = 0;
    for (int cyc = 0; cyc < 40 && !(aw_done && w_done); cyc++) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      awaddr = addr;
      wvalid = !w_done && (cyc >= w_dly);
      wdata = data;
      wstrb = strb;
      #1;
      if (awvalid) check("awready", 32'(awready), 32'd1);
      if (wvalid) check("wready", 32'(wready), 32'd1);
      aw_hs = awvalid && awready;
      w_hs = wvalid && wready;
      if ((aw_done || aw_hs) && (w_done || w_hs)) begin
        check("wr_en_commit", 32'(wr_en), 32'(exp_en));
        if (ok) check("register_write", register_write, newv);
      end else begin
        check("wr_en_idle", 32'(wr_en), 32'd0);
      end
      @(posedge clk);
      #1;
      aw_done |= aw_hs;
      w_done |= w_hs;
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    if (!(aw_done && w_done)) check("write_accept_timeout", 32'd0, 32'd1);
    if (ok) mem[idx] = newv;
    check_regs();
    check("wr_en_after", 32'(wr_en), 32'd0);
    check("bvalid", 32'(bvalid), 32'd1);
    check("bresp", 32'(bresp), ok ? 32'd0 : 32'd2);
    resp = bresp;
    for (int i = 0; i < b_dly; i++) begin
      @(posedge clk);
      #1;
      check("bvalid_hold", 32'(bvalid), 32'd1);
      check("awready_hold", 32'(awready), 32'd0);
      check("wready_hold", 32'(wready), 32'd0);
    end
    bready = 1'b1;
    @(posedge clk);
    #1;
    bready = 1'b0;
    check("bvalid_clear", 32'(bvalid), 32'd0);
    check("awready_after_b", 32'(awready), 32'd1);
    check("wready_after_b", 32'(wready), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int r_dly,
                         output logic [31:0] data, output logic [1:0] resp);
    bit ok;
    logic [31:0] exp_d;
    logic [1:0] exp_r;
    ok = m_in_range(addr);
    exp_d = ok ? mem[m_index(addr)] : 32'h0;
    exp_r = ok ? 2'b00 : 2'b11;
    arvalid = 1'b1;
    araddr = addr;
    #1;
    check("arready", 32'(arready), 32'd1);
    check("rvalid_pre", 32'(rvalid), 32'd0);
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    check("rvalid", 32'(rvalid), 32'd1);
    check("rdata", rdata, exp_d);
    check("rresp", 32'(rresp), 32'(exp_r));
    data = rdata;
    resp = rresp;
    for (int i = 0; i < r_dly; i++) begin
      @(posedge clk);
      #1;
      check("rvalid_hold", 32'(rvalid), 32'd1);
      check("rdata_hold", rdata, exp_d);
      check("rresp_hold", 32'(rresp), 32'(exp_r));
      check("arready_hold", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    @(posedge clk);
    #1;
    rready = 1'b0;
    check("rvalid_clear", 32'(rvalid), 32'd0);
    check("arready_after_r", 32'(arready), 32'd1);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    reset = 1'b1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; awprot = 0;

    tbl[0] = '{1'b1, 32'h00, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    tbl[1] = '{1'b0, 32'h00, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 32'h04, 32'h12345678, 4'h5, 2'b00, 32'h0};
    tbl[3] = '{1'b0, 32'h07, 32'h0,        4'h0, 2'b00, 32'h00340078};
    tbl[4] = '{1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0};
    tbl[5] = '{1'b0, 32'h40, 32'h0,        4'h0, 2'b11, 32'h0};
    tbl[6] = '{1'b1, 32'h0C, 32'hAABBCCDD, 4'h8, 2'b00, 32'h0};
    tbl[7] = '{1'b0, 32'h0C, 32'h0,        4'h0, 2'b00, 32'hAA000000};
    tbl[8] = '{1'b1, 32'h08, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0};
    tbl[9] = '{1'b0, 32'h10, 32'h0,        4'h0, 2'b11, 32'h0};

    do_reset();

    // Read of START after reset
    do_read(32'(START), 0, d, r);
    check("req015_rdata", d, 32'h0);
    check("req015_rresp", 32'(r), 32'd0);

    // Same-cycle AW+W, then W-first partial write
    do_write(32'h0, 32'hDEADBEEF, 4'hF, 0, 0, 0, r);
    check("req016_reg0", registers[0], 32'hDEADBEEF);
    check("req016_bresp", 32'(r), 32'd0);
    do_write(32'h0, 32'h11112222, 4'h3, 3, 0, 0, r);
    check("req017_reg0", registers[0], 32'hDEAD2222);

    // Out-of-range write, long B stall, long R stall
    do_write(32'h40, 32'h5A5A5A5A, 4'hF, 0, 1, 0, r);
    check("req018_bresp", 32'(r), 32'd2);
    do_write(32'h4, 32'h01020304, 4'hF, 1, 0, 5, r);
    do_read(32'h40, 3, d, r);
    check("req020_rdata", d, 32'h0);
    check("req020_rresp", 32'(r), 32'd3);

    // Read and write to the same register on the same edge returns old data
    awvalid = 1; awaddr = 32'h0; wvalid = 1; wdata = 32'h55555555; wstrb = 4'hF;
    arvalid = 1; araddr = 32'h0;
    @(posedge clk);
    #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("same_edge_rdata", rdata, mem[0]);
    mem[0] = 32'h55555555;
    check("same_edge_reg0", registers[0], 32'h55555555);
    check("same_edge_bvalid", 32'(bvalid), 32'd1);
    bready = 1; rready = 1;
    @(posedge clk);
    #1;
    bready = 0; rready = 0;
    check("same_edge_bclr", 32'(bvalid), 32'd0);
    check("same_edge_rclr", 32'(rvalid), 32'd0);

    // Reset with an address held must discard it
    awvalid = 1; awaddr = 32'h4;
    @(posedge clk);
    #1;
    awvalid = 0;
    check("aw_held_awready", 32'(awready), 32'd0);
    do_reset();
    do_write(32'h0, 32'h0BADF00D, 4'hF, 2, 0, 0, r);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, i % 3, (i + 1) % 3, i % 2, r);
        check("tbl_bresp", 32'(r), 32'(tbl[i].resp));
      end else begin
        do_read(tbl[i].addr, i % 3, d, r);
        check("tbl_rdata", d, tbl[i].rdata);
        check("tbl_rresp", 32'(r), 32'(tbl[i].resp));
      end
    end

    for (int n = 0; n < 120; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 4) == 0) a = 32'h40 + 32'($urandom_range(0, 63));
      else a = 32'($urandom_range(0, 4 * REG_CNT - 1));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), r);
      else
        do_read(a, int'($urandom_range(0, 2)), d, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
